// File: rtl/caesar_pkg.sv
// Shared types and constants for the Caesar-coded urna digit decoder.
package caesar_pkg;

  // Key the urna encoder applies to every digit before Johnson encoding.
  localparam int unsigned DEFAULT_SHIFT = 7;

  // Vote assembly states: waiting for tens, waiting for units, holding a vote.
  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  // The ten legal 5-bit Johnson codes, listed in index order (bit 4 = S4).
  localparam logic [4:0] JC_0 = 5'b00000;
  localparam logic [4:0] JC_1 = 5'b10000;
  localparam logic [4:0] JC_2 = 5'b11000;
  localparam logic [4:0] JC_3 = 5'b11100;
  localparam logic [4:0] JC_4 = 5'b11110;
  localparam logic [4:0] JC_5 = 5'b11111;
  localparam logic [4:0] JC_6 = 5'b01111;
  localparam logic [4:0] JC_7 = 5'b00111;
  localparam logic [4:0] JC_8 = 5'b00011;
  localparam logic [4:0] JC_9 = 5'b00001;

  // Undo the Caesar shift: (idx + 10 - shift) mod 10. Operands are 0..9, so
  // the 5-bit sum stays within 1..19 and one conditional subtract suffices.
  function automatic logic [3:0] unshift_digit(input logic [3:0] idx,
                                               input logic [3:0] shift);
    logic [4:0] sum;
    sum = {1'b0, idx} + 5'd10 - {1'b0, shift};
    if (sum >= 5'd10) sum = sum - 5'd10;
    return 4'(sum);
  endfunction

endpackage

// File: rtl/johnson_index.sv
// Combinational lookup from a 5-bit Johnson code to its index 0..9.
module johnson_index
  import caesar_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [3:0] idx_o,
  output logic       legal_o
);

  // Decode the ten legal patterns; everything else is flagged illegal.
  always_comb begin
    // NOTE: outputs get defaults before the case so no path can infer a latch.
    idx_o   = 4'd0;
    legal_o = 1'b1;
    case (code_i)
      JC_0:    idx_o = 4'd0;
      JC_1:    idx_o = 4'd1;
      JC_2:    idx_o = 4'd2;
      JC_3:    idx_o = 4'd3;
      JC_4:    idx_o = 4'd4;
      JC_5:    idx_o = 4'd5;
      JC_6:    idx_o = 4'd6;
      JC_7:    idx_o = 4'd7;
      JC_8:    idx_o = 4'd8;
      JC_9:    idx_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/caesar_decoder.sv
// Decodes Caesar-shifted Johnson digits and assembles two-digit BCD votes.
module caesar_decoder
  import caesar_pkg::*;
#(
  parameter int unsigned SHIFT = DEFAULT_SHIFT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       code_err,
  output logic [7:0] vote,
  output logic       vote_valid,
  input  logic       vote_ack
);

  localparam logic [3:0] SHIFT_KEY = 4'(SHIFT);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       code_err_q, code_err_d;
  logic [7:0] vote_q, vote_d;

  logic [3:0] code_idx;
  logic       code_legal;
  logic [3:0] dec_digit;
  logic       accept;

  johnson_index u_johnson_index (
    .code_i  (code_in),
    .idx_o   (code_idx),
    .legal_o (code_legal)
  );

  assign dec_digit   = unshift_digit(code_idx, SHIFT_KEY);
  assign code_ready  = (state_q != S_HOLD);
  assign accept      = code_valid && code_ready;
  assign vote_valid  = (state_q == S_HOLD);
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign code_err    = code_err_q;
  assign vote        = vote_q;

  // Next-state and datapath: accept codes in the entry states, release the
  // held vote on acknowledge. Pulses default low and last one cycle.
  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    digit_d       = digit_q;
    vote_d        = vote_q;
    digit_valid_d = 1'b0;
    code_err_d    = 1'b0;
    case (state_q)
      S_FIRST: begin
        if (accept) begin
          if (code_legal) begin
            digit_d       = dec_digit;
            digit_valid_d = 1'b1;
            tens_d        = dec_digit;
            state_d       = S_SECOND;
          end else begin
            code_err_d = 1'b1;
          end
        end
      end
      S_SECOND: begin
        if (accept) begin
          if (code_legal) begin
            digit_d       = dec_digit;
            digit_valid_d = 1'b1;
            vote_d        = {tens_q, dec_digit};
            state_d       = S_HOLD;
          end else begin
            // An illegal units code abandons the partially entered vote.
            code_err_d = 1'b1;
            state_d    = S_FIRST;
          end
        end
      end
      S_HOLD: begin
        if (vote_ack) state_d = S_FIRST;
      end
      default: state_d = S_FIRST;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FIRST;
      tens_q        <= 4'd0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      vote_q        <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      tens_q        <= tens_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      code_err_q    <= code_err_d;
      vote_q        <= vote_d;
    end
  end

endmodule
